// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states, op encoding and requester count for the adder arbiter
package alu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int N_REQ = 2;
endpackage

// File: rtl/sum8b.sv
// sum8b: 8-bit add/subtract with carry-out (no-borrow on subtract) and signed overflow
module sum8b
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic [7:0] s,
  output logic       cout,
  output logic       ovf
);
  logic       sub;
  logic [7:0] bb;
  logic [8:0] sum;
  assign sub  = sel == OP_SUB;
  assign bb   = sub ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, bb} + {8'b0, sub};
  assign s    = sum[7:0];
  assign cout = sum[8];
  assign ovf  = (a[7] == bb[7]) && (s[7] != a[7]);
endmodule

// File: rtl/sum8b_arbiter.sv
// sum8b_arbiter: round-robin time-sharing of one sum8b between two valid/ready requesters
module sum8b_arbiter
  import alu_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req0_b,
  input  logic [7:0]       req1_b,
  input  logic             req0_sel,
  input  logic             req1_sel,
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output logic [7:0]       rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  state_t     state;
  logic       last_grant;
  logic       id;
  logic       win;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_sel;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  // on a tie the requester that was not served last wins
  assign win       = &req_valid ? ~last_grant : req_valid[1];
  assign req_ready = (state == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = state == RESP ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = state != IDLE;
  sum8b u_sum (
    .a(op_a),
    .b(op_b),
    .sel(op_sel),
    .s(s),
    .cout(cout),
    .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ~PRIO_RESET;
      rsp_s      <= 8'h00;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          op_a       <= win ? req1_a : req0_a;
          op_b       <= win ? req1_b : req0_b;
          op_sel     <= win ? req1_sel : req0_sel;
          id         <= win;
          last_grant <= win;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_s    <= s;
          rsp_cout <= cout;
          rsp_ovf  <= ovf;
          state    <= RESP;
        end
        RESP: if (rsp_ready[id]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sum8b_arbiter.sv
// tb_sum8b_arbiter: directed table, hand sequences and random ops against an arithmetic reference model
module tb_sum8b_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req0_a = 8'h00, req1_a = 8'h00, req0_b = 8'h00, req1_b = 8'h00;
  logic       req0_sel = 1'b0, req1_sel = 1'b0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [7:0] rsp_s;
  logic       rsp_cout, rsp_ovf, busy;
  int total = 0;
  int bad = 0;

  sum8b_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sel,
                                output logic [7:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sel ? ua - ub : ua + ub;
    s  = r[7:0];
    c  = sel ? (ua >= ub) : (r > 255);
    sr = sel ? sa - sb : sa + sb;
    o  = (sr > 127) || (sr < -128);
  endfunction

  task automatic set_ops(input int who, input logic [7:0] a, input logic [7:0] b, input logic sel);
    if (who == 0) begin
      req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b, input logic sel,
                        input logic [7:0] es, input logic ec, input logic eo, input int hold);
    int n;
    logic [1:0] oh;
    oh = who == 0 ? 2'b01 : 2'b10;
    @(negedge clk);
    set_ops(who, a, b, sel);
    req_valid = oh;
    rsp_ready = 2'b00;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("req_ready", int'(req_ready), int'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n = 1;
    while (rsp_valid == 2'b00 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("latency", n, 2);
    chk("rsp_valid", int'(rsp_valid), int'(oh));
    chk("rsp_s", int'(rsp_s), int'(es));
    chk("rsp_cout", int'(rsp_cout), int'(ec));
    chk("rsp_ovf", int'(rsp_ovf), int'(eo));
    repeat (hold) begin
      @(negedge clk); #1;
      chk("hold_valid", int'(rsp_valid), int'(oh));
      chk("hold_s", int'(rsp_s), int'(es));
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("rsp_drop", int'(rsp_valid), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int g, r, w;
    int q[$];
    logic [7:0] es;
    logic ec, eo;
    vecs[0] = '{0, 8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[3] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{0, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    do_reset();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_s", int'(rsp_s), 0);
    chk("rst_cout", int'(rsp_cout), 0);
    chk("rst_ovf", int'(rsp_ovf), 0);
    chk("rst_busy", int'(busy), 0);

    foreach (vecs[i])
      run_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].s, vecs[i].c, vecs[i].o, 0);

    // contention: both requesters hold valid, responses consumed immediately
    do_reset();
    set_ops(0, 8'h11, 8'h22, 1'b0);
    set_ops(1, 8'h50, 8'h30, 1'b1);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    g = 0;
    r = 0;
    for (int cyc = 0; cyc < 40 && (g < 4 || r < 4); cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("grant_order", int'(req_ready), (g % 2) == 1 ? 2 : 1);
        q.push_back(req_ready == 2'b10 ? 1 : 0);
        g++;
      end
      if (rsp_valid != 2'b00) begin
        w = q.size() > 0 ? q.pop_front() : -1;
        chk("cont_rsp_valid", int'(rsp_valid), w == 1 ? 2 : 1);
        if (w == 1) model(8'h50, 8'h30, 1'b1, es, ec, eo);
        else model(8'h11, 8'h22, 1'b0, es, ec, eo);
        chk("cont_rsp_s", int'(rsp_s), int'(es));
        r++;
      end
      if (g < 4 || r < 4) @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("cont_grants", g, 4);
    chk("cont_rsps", r, 4);

    // backpressure: requester 0 held in RESP while requester 1 waits
    @(negedge clk);
    set_ops(0, 8'h33, 8'h44, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("bp_grant0", int'(req_ready), 1);
    @(negedge clk);
    set_ops(1, 8'h05, 8'h09, 1'b1);
    req_valid = 2'b11;
    #1;
    chk("bp_exec_ready", int'(req_ready), 0);
    @(negedge clk); #1;
    chk("bp_rsp_valid", int'(rsp_valid), 1);
    chk("bp_rsp_s", int'(rsp_s), 8'h77);
    rsp_ready = 2'b10;
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_s", int'(rsp_s), 8'h77);
      chk("bp_hold_ready", int'(req_ready), 0);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    #1;
    chk("bp_release", int'(rsp_valid), 0);
    chk("bp_grant1", int'(req_ready), 2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("bp_rsp1_valid", int'(rsp_valid), 2);
    chk("bp_rsp1_s", int'(rsp_s), 8'hFC);
    chk("bp_rsp1_cout", int'(rsp_cout), 0);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // reset while in EXEC after a result with cout and ovf set
    model(8'h90, 8'h90, 1'b0, es, ec, eo);
    run_op(0, 8'h90, 8'h90, 1'b0, es, ec, eo, 1);
    @(negedge clk);
    set_ops(0, 8'h01, 8'h02, 1'b0);
    req_valid = 2'b01;
    #1;
    chk("mid_grant", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("mid_exec_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rsp_s", int'(rsp_s), 0);
    chk("mid_cout", int'(rsp_cout), 0);
    chk("mid_ovf", int'(rsp_ovf), 0);
    repeat (4) begin
      @(negedge clk); #1;
      chk("mid_no_rsp", int'(rsp_valid), 0);
    end

    for (int k = 0; k < 40; k++) begin
      int who;
      logic [7:0] a, b;
      logic sel;
      who = int'($urandom_range(1, 0));
      a = 8'($urandom);
      b = 8'($urandom);
      sel = 1'($urandom);
      model(a, b, sel, es, ec, eo);
      run_op(who, a, b, sel, es, ec, eo, int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
